// File: rtl/ssd_capture_decoder_if.sv
// Bus between a seven-segment display tap and the capture decoder: raw pins in,
// per-position readback and status out.
interface ssd_capture_decoder_if;
  logic [3:0] anode;
  logic [6:0] cathode;
  logic [1:0] rd_sel;
  logic [2:0] rd_digit;
  logic       rd_valid;
  logic       frame_done;
  logic       err_pattern;
  logic       err_anode;
  logic       err_clr;

  modport master (
    output anode,
    output cathode,
    output rd_sel,
    output err_clr,
    input  rd_digit,
    input  rd_valid,
    input  frame_done,
    input  err_pattern,
    input  err_anode
  );

  modport slave (
    input  anode,
    input  cathode,
    input  rd_sel,
    input  err_clr,
    output rd_digit,
    output rd_valid,
    output frame_done,
    output err_pattern,
    output err_anode
  );
endinterface

// File: rtl/ssd_capture_decoder.sv
// Captures digits 0..7 from a multiplexed, active-low 4-digit seven-segment display
// by synchronizing the pins, waiting for a stable window, and decoding anode/cathode.
module ssd_capture_decoder #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  ssd_capture_decoder_if.slave bus
);

  localparam int unsigned AN_W   = 4;
  localparam int unsigned CA_W   = 7;
  localparam int unsigned SYNC_W = AN_W + CA_W;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned POS_N  = 4;
  localparam int unsigned DIG_W  = 3;
  localparam int unsigned POS_W  = 2;

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ARM  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [SYNC_W-1:0] SYNC_RST = {SYNC_W{1'b1}};
  localparam logic [POS_N-1:0]  SEEN_ALL = {POS_N{1'b1}};

  // Pin synchronizer, previous-cycle copy and stability counter
  logic [SYNC_W-1:0] sync1_q, sync1_d;
  logic [SYNC_W-1:0] sync2_q, sync2_d;
  logic [SYNC_W-1:0] prev_q,  prev_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  // Captured state
  logic [POS_N-1:0][DIG_W-1:0] digit_q, digit_d;
  logic [POS_N-1:0]            seen_q,  seen_d;
  logic                        frame_done_q, frame_done_d;
  logic                        err_pattern_q, err_pattern_d;
  logic                        err_anode_q,   err_anode_d;

  // Combinational decode of the synchronized sample
  logic [AN_W-1:0]  s_anode;
  logic [CA_W-1:0]  s_cathode;
  logic             changed;
  logic             capture;
  logic             pos_vld;
  logic             anode_blank;
  logic [POS_W-1:0] pos;
  logic             pat_ok;
  logic [DIG_W-1:0] pat_digit;

  assign s_anode   = sync2_q[SYNC_W-1:CA_W];
  assign s_cathode = sync2_q[CA_W-1:0];

  // Anode: exactly one line low selects a position; all high is a blanking slot
  always_comb begin
    pos_vld     = 1'b0;
    anode_blank = 1'b0;
    pos         = '0;
    case (s_anode)
      4'b0111: begin pos_vld = 1'b1; pos = 2'd0; end
      4'b1011: begin pos_vld = 1'b1; pos = 2'd1; end
      4'b1101: begin pos_vld = 1'b1; pos = 2'd2; end
      4'b1110: begin pos_vld = 1'b1; pos = 2'd3; end
      4'b1111: anode_blank = 1'b1;
      default: ;
    endcase
  end

  // Cathode {a..g}, active-low: only glyphs 0..7 are recognized
  always_comb begin
    pat_ok    = 1'b1;
    pat_digit = '0;
    case (s_cathode)
      7'b0000001: pat_digit = 3'd0;
      7'b1001111: pat_digit = 3'd1;
      7'b0010010: pat_digit = 3'd2;
      7'b0000110: pat_digit = 3'd3;
      7'b1001100: pat_digit = 3'd4;
      7'b0100100: pat_digit = 3'd5;
      7'b0100000: pat_digit = 3'd6;
      7'b0001111: pat_digit = 3'd7;
      default:    pat_ok    = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    sync1_d       = {bus.anode, bus.cathode};
    sync2_d       = sync1_q;
    prev_d        = sync2_q;
    cnt_d         = cnt_q;
    digit_d       = digit_q;
    seen_d        = seen_q;
    frame_done_d  = 1'b0;
    err_pattern_d = err_pattern_q & ~bus.err_clr;
    err_anode_d   = err_anode_q & ~bus.err_clr;

    changed = (sync2_q != prev_q);
    // Fires on the single edge where the counter steps ARM -> MAX
    capture = !changed && (cnt_q == CNT_ARM);

    if (changed) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A completed frame announces itself one cycle later and restarts collection
    if (seen_q == SEEN_ALL) begin
      frame_done_d = 1'b1;
      seen_d       = '0;
    end

    if (capture) begin
      if (pos_vld) begin
        if (pat_ok) begin
          digit_d[pos] = pat_digit;
          seen_d[pos]  = 1'b1;
        end else begin
          err_pattern_d = 1'b1;
        end
      end else if (!anode_blank) begin
        err_anode_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= SYNC_RST;
      sync2_q       <= SYNC_RST;
      prev_q        <= SYNC_RST;
      cnt_q         <= '0;
      digit_q       <= '0;
      seen_q        <= '0;
      frame_done_q  <= 1'b0;
      err_pattern_q <= 1'b0;
      err_anode_q   <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      digit_q       <= digit_d;
      seen_q        <= seen_d;
      frame_done_q  <= frame_done_d;
      err_pattern_q <= err_pattern_d;
      err_anode_q   <= err_anode_d;
    end
  end

  // Readback mux is combinational from the registers
  assign bus.rd_digit    = digit_q[bus.rd_sel];
  assign bus.rd_valid    = seen_q[bus.rd_sel];
  assign bus.frame_done  = frame_done_q;
  assign bus.err_pattern = err_pattern_q;
  assign bus.err_anode   = err_anode_q;

endmodule
